// File: rtl/age_oldest_select_if.sv
// Issue-queue age selection bundle: enqueue, dequeue,
// readiness and normal-select inputs, plus oldest/override results.
interface age_oldest_select_if #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_ENQ   = 2,
  parameter int NUM_SEL   = 2
);

  logic [NUM_ENQ-1:0]           io_enq_valid;
  logic [NUM_ENQ*NUM_ENTRY-1:0] io_enq_bits;
  logic [NUM_ENTRY-1:0]         io_deq_mask;
  logic                         io_flush;
  logic [NUM_ENTRY-1:0]         io_ready;
  logic [NUM_SEL-1:0]           io_in_valid;
  logic [NUM_SEL*NUM_ENTRY-1:0] io_in_bits;
  logic                         io_oldest_valid;
  logic [NUM_ENTRY-1:0]         io_oldest_bits;
  logic [NUM_SEL-1:0]           io_isOverrided;

  modport master (
    output io_enq_valid,
    output io_enq_bits,
    output io_deq_mask,
    output io_flush,
    output io_ready,
    output io_in_valid,
    output io_in_bits,
    input  io_oldest_valid,
    input  io_oldest_bits,
    input  io_isOverrided
  );

  modport slave (
    input  io_enq_valid,
    input  io_enq_bits,
    input  io_deq_mask,
    input  io_flush,
    input  io_ready,
    input  io_in_valid,
    input  io_in_bits,
    output io_oldest_valid,
    output io_oldest_bits,
    output io_isOverrided
  );

endinterface

// File: rtl/age_oldest_select.sv
// Age-matrix oldest-ready picker for an issue queue; the
// registered pick can override the last normal select port.
module age_oldest_select #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_ENQ   = 2,
  parameter int NUM_SEL   = 2
) (
  input logic                clock,
  input logic                reset,
  age_oldest_select_if.slave io
);

  localparam int NE = NUM_ENTRY;

  logic [NE-1:0]           valid_q;
  logic [NE-1:0]           valid_d;
  logic [NE-1:0][NE-1:0]   age_q;
  logic [NE-1:0][NE-1:0]   age_d;
  logic [NE-1:0]           oldest_q;
  logic                    oldest_v_q;

  logic [NE-1:0]           enq_any;
  logic [NE-1:0][NUM_ENQ-1:0] pre;
  logic                    run;
  logic [NE-1:0]           rdy;
  logic [NE-1:0]           cand;
  logic                    cbit;
  logic                    match;
  logic                    old_vld;

  // pre[i] is a thermometer starting at the first port that
  // targets slot i; a strictly lower start means older.
  always_comb begin
    pre     = '0;
    enq_any = '0;
    run     = 1'b0;
    for (int i = 0; i < NE; i++) begin
      run = 1'b0;
      for (int k = 0; k < NUM_ENQ; k++) begin
        run = run
            | (io.io_enq_valid[k]
            & io.io_enq_bits[k*NE+i]);
        pre[i][k] = run;
      end
      enq_any[i] = run;
    end
  end

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NE; i++) begin
      for (int j = 0; j < NE; j++) begin
        if (i != j) begin
          if (enq_any[i] && enq_any[j]) begin
            age_d[i][j] = |(pre[i] & ~pre[j]);
          end else if (enq_any[j] && valid_q[i]) begin
            age_d[i][j] = 1'b1;
          end else if (enq_any[i] && valid_q[j]) begin
            age_d[i][j] = 1'b0;
          end
        end
      end
    end
  end

  assign valid_d = (valid_q & ~io.io_deq_mask)
                 | enq_any;

  assign rdy = io.io_ready
             & valid_q
             & ~io.io_deq_mask;

  always_comb begin
    cand = '0;
    cbit = 1'b0;
    for (int i = 0; i < NE; i++) begin
      cbit = rdy[i];
      for (int j = 0; j < NE; j++) begin
        if (i != j) begin
          cbit = cbit & (~rdy[j] | age_q[i][j]);
        end
      end
      cand[i] = cbit;
    end
  end

  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_SEL; k++) begin
      match = match
            | (io.io_in_valid[k]
            & |(io.io_in_bits[k*NE +: NE] & oldest_q));
    end
  end

  // A pick whose slot leaves this cycle is stale.
  assign old_vld = oldest_v_q
                 & ~|(oldest_q & io.io_deq_mask)
                 & ~io.io_flush;

  always_comb begin
    io.io_isOverrided = '0;
    io.io_isOverrided[NUM_SEL-1] = old_vld & ~match;
  end

  assign io.io_oldest_valid = old_vld;
  assign io.io_oldest_bits  = oldest_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      age_q      <= '0;
      oldest_q   <= '0;
      oldest_v_q <= 1'b0;
    end else if (io.io_flush) begin
      valid_q    <= '0;
      oldest_v_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      age_q      <= age_d;
      oldest_q   <= cand;
      oldest_v_q <= |rdy;
    end
  end

endmodule

// File: tb/tb_age_oldest_select.sv
// Directed and random checks of age_oldest_select against a
// sequence-number reference model.
module tb_age_oldest_select;

  localparam int NE = 16;
  localparam int NQ = 2;
  localparam int NS = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [NE-1:0]    m_valid;
  int unsigned      m_seq [NE];
  int unsigned      m_cnt;
  logic [NE-1:0]    m_oq;
  logic             m_ov;
  bit               do_check;

  age_oldest_select_if #(
    .NUM_ENTRY(NE), .NUM_ENQ(NQ), .NUM_SEL(NS)
  ) ifc ();

  age_oldest_select #(
    .NUM_ENTRY(NE), .NUM_ENQ(NQ), .NUM_SEL(NS)
  ) dut (
    .clock(clk),
    .reset(rst),
    .io   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifc.io_enq_valid = '0;
    ifc.io_enq_bits  = '0;
    ifc.io_deq_mask  = '0;
    ifc.io_flush     = 1'b0;
    ifc.io_ready     = '0;
    ifc.io_in_valid  = '0;
    ifc.io_in_bits   = '0;
    rst              = 1'b0;
  endtask

  // Compare outputs of the current cycle with the model.
  task automatic settle_check();
    logic       e_ov;
    logic       mt;
    logic [1:0] e_ovr;
    #2;
    if (do_check) begin
      e_ov = m_ov & ~|(m_oq & ifc.io_deq_mask)
           & ~ifc.io_flush;
      mt = 1'b0;
      for (int k = 0; k < NS; k++)
        if (ifc.io_in_valid[k] &&
            |(ifc.io_in_bits[k*NE +: NE] & m_oq))
          mt = 1'b1;
      e_ovr = {e_ov & ~mt, 1'b0};
      chk("oldest_valid", 32'(ifc.io_oldest_valid),
          32'(e_ov));
      chk("oldest_bits", 32'(ifc.io_oldest_bits),
          32'(m_oq));
      chk("isOverrided", 32'(ifc.io_isOverrided),
          32'(e_ovr));
    end
  endtask

  // Model the clock edge, then move to the next negedge.
  task automatic advance();
    logic [NE-1:0] rdy;
    logic [NE-1:0] cand;
    int            best;
    int unsigned   bs;
    if (rst) begin
      m_valid = '0;
      m_oq    = '0;
      m_ov    = 1'b0;
    end else begin
      rdy  = ifc.io_ready & m_valid & ~ifc.io_deq_mask;
      cand = '0;
      best = -1;
      bs   = 0;
      for (int i = 0; i < NE; i++)
        if (rdy[i] && (best < 0 || m_seq[i] < bs)) begin
          best = i;
          bs   = m_seq[i];
        end
      if (best >= 0) cand[best] = 1'b1;
      if (ifc.io_flush) begin
        m_valid = '0;
        m_ov    = 1'b0;
      end else begin
        m_oq    = cand;
        m_ov    = |rdy;
        m_valid = m_valid & ~ifc.io_deq_mask;
        for (int k = 0; k < NQ; k++)
          if (ifc.io_enq_valid[k])
            for (int i = 0; i < NE; i++)
              if (ifc.io_enq_bits[k*NE+i]) begin
                chk("enq_to_valid_slot",
                    32'(m_valid[i]), 32'd0);
                m_valid[i] = 1'b1;
                m_seq[i]   = m_cnt;
                m_cnt++;
              end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic rand_drive();
    logic [NE-1:0] used;
    int            s;
    idle();
    ifc.io_ready    = NE'($urandom);
    ifc.io_deq_mask = m_valid & NE'($urandom)
                    & NE'($urandom) & NE'($urandom);
    ifc.io_flush    = ($urandom_range(0, 39) == 0);
    rst             = ($urandom_range(0, 99) == 0);
    used = m_valid;
    for (int k = 0; k < NQ; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, NE-1);
        if (!used[s]) begin
          ifc.io_enq_valid[k]     = 1'b1;
          ifc.io_enq_bits[k*NE+s] = 1'b1;
          used[s] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NS; k++) begin
      ifc.io_in_valid[k] = 1'($urandom);
      if ($urandom_range(0, 2) == 0)
        ifc.io_in_bits[k*NE +: NE] = m_oq;
      else
        ifc.io_in_bits[k*NE +: NE] =
          NE'(1) << $urandom_range(0, NE-1);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    m_valid  = '0;
    m_oq     = '0;
    m_ov     = 1'b0;
    m_cnt    = 0;
    do_check = 1'b0;
    for (int i = 0; i < NE; i++) m_seq[i] = 0;
    idle();

    // T1: reset held two cycles with activity.
    rst = 1'b1;
    ifc.io_enq_valid = 2'b01;
    ifc.io_enq_bits  = 32'h0000_0001;
    ifc.io_ready     = 16'hffff;
    step();
    step();
    idle();
    do_check = 1'b1;
    settle_check();
    chk("t1_valid", 32'(ifc.io_oldest_valid), 32'd0);
    chk("t1_ovr", 32'(ifc.io_isOverrided), 32'd0);
    advance();

    // T2: slot 5 then slot 2.
    ifc.io_enq_valid = 2'b01;
    ifc.io_enq_bits  = 32'h0000_0020;
    step();
    ifc.io_enq_bits  = 32'h0000_0004;
    step();
    idle();
    ifc.io_ready = 16'h0024;
    step();
    settle_check();
    chk("t2_bits", 32'(ifc.io_oldest_bits), 32'h0020);
    chk("t2_valid", 32'(ifc.io_oldest_valid), 32'd1);
    advance();

    // T3: same-cycle enqueue, port 0 older.
    idle();
    ifc.io_flush = 1'b1;
    step();
    idle();
    ifc.io_enq_valid = 2'b11;
    ifc.io_enq_bits  = 32'h0008_0200;
    step();
    idle();
    ifc.io_ready = 16'h0208;
    step();
    ifc.io_deq_mask = 16'h0200;
    settle_check();
    chk("t3_bits0", 32'(ifc.io_oldest_bits), 32'h0200);
    advance();
    ifc.io_deq_mask = '0;
    settle_check();
    chk("t3_bits1", 32'(ifc.io_oldest_bits), 32'h0008);
    chk("t3_valid1", 32'(ifc.io_oldest_valid), 32'd1);
    advance();

    // T4: override.
    idle();
    ifc.io_flush = 1'b1;
    step();
    idle();
    ifc.io_enq_valid = 2'b01;
    ifc.io_enq_bits  = 32'h0000_0020;
    step();
    idle();
    ifc.io_ready = 16'h0020;
    step();
    ifc.io_in_valid = 2'b10;
    ifc.io_in_bits  = 32'h0020_0000;
    settle_check();
    chk("t4_match", 32'(ifc.io_isOverrided), 32'd0);
    advance();
    ifc.io_in_valid = 2'b11;
    ifc.io_in_bits  = 32'h0004_0001;
    settle_check();
    chk("t4_override", 32'(ifc.io_isOverrided), 32'h2);
    advance();

    // T5: stale kill, then flush beats enqueue.
    ifc.io_in_valid = '0;
    ifc.io_in_bits  = '0;
    ifc.io_deq_mask = 16'h0020;
    settle_check();
    chk("t5_stale_v", 32'(ifc.io_oldest_valid), 32'd0);
    chk("t5_stale_o", 32'(ifc.io_isOverrided), 32'd0);
    advance();
    idle();
    ifc.io_enq_valid = 2'b01;
    ifc.io_enq_bits  = 32'h0000_0002;
    ifc.io_flush     = 1'b1;
    ifc.io_ready     = 16'hffff;
    step();
    idle();
    ifc.io_ready = 16'hffff;
    settle_check();
    chk("t5_flush_v", 32'(ifc.io_oldest_valid), 32'd0);
    chk("t5_flush_o", 32'(ifc.io_isOverrided), 32'd0);
    advance();
    settle_check();
    chk("t5_cleared", 32'(ifc.io_oldest_valid), 32'd0);
    advance();

    // T6: enqueue and dequeue the same slot.
    idle();
    ifc.io_enq_valid = 2'b01;
    ifc.io_enq_bits  = 32'h0000_0080;
    step();
    ifc.io_enq_bits  = 32'h0000_0004;
    step();
    ifc.io_enq_bits  = 32'h0000_0080;
    ifc.io_deq_mask  = 16'h0080;
    step();
    idle();
    ifc.io_ready = 16'h0084;
    step();
    ifc.io_deq_mask = 16'h0004;
    settle_check();
    chk("t6_older", 32'(ifc.io_oldest_bits), 32'h0004);
    advance();
    ifc.io_deq_mask = '0;
    settle_check();
    chk("t6_young", 32'(ifc.io_oldest_bits), 32'h0080);
    chk("t6_valid", 32'(ifc.io_oldest_valid), 32'd1);
    advance();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rand_drive();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
